// File: rtl/data_memory_mmio.sv
// rtl/data_memory_mmio.sv - word RAM with memory-mapped switches, LEDs, cycle counter and compare timer
// Optional macro: DATA_MEMORY_MMIO_DEBOUNCE_EN (debounce the synchronised switch vector)
`timescale 1ns/1ps

module data_memory_mmio #(
   parameter int unsigned DEPTH_LOG2      = 8,
   parameter int unsigned SW_W            = 8,
   parameter int unsigned LED_W           = 8,
   parameter logic [31:0] IO_BASE         = 32'h0000_0090,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_write_en,
   input  logic [31:0]      addr,
   input  logic [31:0]      write_data,
   input  logic [1:0]       mem_size,
   input  logic             mem_unsigned,
   input  logic [SW_W-1:0]  switches,
   output logic [LED_W-1:0] leds,
   output logic [31:0]      read_data,
   output logic             misaligned,
   output logic             timer_irq
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   // Reject illegal configurations at elaboration time.
   if ((IO_BASE[1:0] != 2'b00) || (SW_W < 1) || (SW_W > 32) ||
       (LED_W < 1) || (LED_W > 32) || (DEBOUNCE_CYCLES < 2)) begin : g_param_check
      $error("data_memory_mmio: illegal parameter combination");
   end

   logic [31:0]           mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] word_idx;

   logic [SW_W-1:0]  sw_meta_q, sw_sync_q, sw_val;
   logic [LED_W-1:0] leds_q, leds_d;
   logic [31:0]      cnt_q, cnt_d;
   logic [31:0]      cmp_q, cmp_d;
   logic             flag_q, flag_d;

   logic        is_half, is_word;
   logic        sel_sw, sel_led, sel_cnt, sel_cmp, sel_stat, io_hit;
   logic        store_ok, io_we, ram_we, timer_hit, stat_clr;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata, ram_word, ram_shift, ram_load, io_rdata;

   assign word_idx = addr[DEPTH_LOG2+1:2];
   assign is_half  = (mem_size == 2'b01);
   assign is_word  = mem_size[1];

   // Full 32-bit compares: IO_BASE is word aligned, so a hit implies addr[1:0] == 0.
   assign sel_sw   = (addr == IO_BASE);
   assign sel_led  = (addr == IO_BASE + 32'h4);
   assign sel_cnt  = (addr == IO_BASE + 32'h8);
   assign sel_cmp  = (addr == IO_BASE + 32'hC);
   assign sel_stat = (addr == IO_BASE + 32'h10);
   assign io_hit   = sel_sw | sel_led | sel_cnt | sel_cmp | sel_stat;

   assign misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
   assign store_ok   = mem_write_en & ~misaligned;
   assign io_we      = store_ok & io_hit;
   assign ram_we     = store_ok & ~io_hit;

   assign timer_hit = (cnt_q == cmp_q) && (cmp_q != 32'h0);
   assign stat_clr  = io_we & sel_stat & write_data[0];

   // Byte-lane enables and lane-replicated store data for sub-word stores.
   always_comb begin
      ram_be    = 4'b1111;
      ram_wdata = write_data;
      case (mem_size)
         2'b00: begin
            ram_be    = 4'b0001 << addr[1:0];
            ram_wdata = {4{write_data[7:0]}};
         end
         2'b01: begin
            ram_be    = addr[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{write_data[15:0]}};
         end
         default: ram_be = 4'b1111;
      endcase
   end

   // RAM store; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (ram_be[i]) mem_q[word_idx][i*8 +: 8] <= ram_wdata[i*8 +: 8];
         end
      end
   end

   // Combinational RAM load with lane select and sign/zero extension.
   always_comb begin
      ram_word  = mem_q[word_idx];
      ram_shift = ram_word >> {addr[1:0], 3'b000};
      ram_load  = ram_word;
      case (mem_size)
         2'b00:   ram_load = mem_unsigned ? {24'h0, ram_shift[7:0]}
                                          : {{24{ram_shift[7]}}, ram_shift[7:0]};
         2'b01:   ram_load = mem_unsigned ? {16'h0, ram_shift[15:0]}
                                          : {{16{ram_shift[15]}}, ram_shift[15:0]};
         default: ram_load = ram_word;
      endcase
   end

   // IO read mux; full word, no extension.
   always_comb begin
      io_rdata = 32'h0;
      if (sel_sw)        io_rdata[SW_W-1:0]  = sw_val;
      else if (sel_led)  io_rdata[LED_W-1:0] = leds_q;
      else if (sel_cnt)  io_rdata            = cnt_q;
      else if (sel_cmp)  io_rdata            = cmp_q;
      else if (sel_stat) io_rdata[0]         = flag_q;
   end

   assign read_data = misaligned ? 32'h0 : (io_hit ? io_rdata : ram_load);

   // IO next state; a timer hit beats a same-cycle STAT clear.
   always_comb begin
      leds_d = leds_q;
      cmp_d  = cmp_q;
      cnt_d  = cnt_q + 32'd1;
      if (io_we && sel_led) leds_d = write_data[LED_W-1:0];
      if (io_we && sel_cmp) cmp_d  = write_data;
      flag_d = timer_hit | (flag_q & ~stat_clr);
   end

   // IO registers and switch synchroniser.
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         leds_q    <= '0;
         cnt_q     <= 32'h0;
         cmp_q     <= 32'h0;
         flag_q    <= 1'b0;
      end else begin
         sw_meta_q <= switches;
         sw_sync_q <= sw_meta_q;
         leds_q    <= leds_d;
         cnt_q     <= cnt_d;
         cmp_q     <= cmp_d;
         flag_q    <= flag_d;
      end
   end

`ifdef DATA_MEMORY_MMIO_DEBOUNCE_EN
   localparam int unsigned      DB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [SW_W-1:0] db_cand_q, sw_db_q;
   logic [DB_W-1:0] db_cnt_q;

   // Restart on any change; publish once the vector held for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cand_q <= '0;
         db_cnt_q  <= '0;
         sw_db_q   <= '0;
      end else if (sw_sync_q != db_cand_q) begin
         db_cand_q <= sw_sync_q;
         db_cnt_q  <= DB_W'(1);
      end else if (db_cnt_q != DB_LAST) begin
         db_cnt_q  <= db_cnt_q + DB_W'(1);
      end else begin
         sw_db_q   <= db_cand_q;
      end
   end

   assign sw_val = sw_db_q;
`else
   assign sw_val = sw_sync_q;
`endif

   assign leds      = leds_q;
   assign timer_irq = flag_q;

endmodule
